uart_frame: RTL
===============

# uart_frame

Parametrised full-duplex UART: the successor to the fixed 8N1 UART top, with configurable data width, parity mode and stop-bit count. It adds RX parity and framing error reporting, false-start rejection and a ready/valid TX handshake that allows back-to-back frames. It sits between the system clock domain and the asynchronous serial pins. The baud rate is fixed at elaboration by `CLKS_PER_BIT`.

## Interface
- `CLKS_PER_BIT`, 87, system clocks per bit period; must be ≥ 4.
- `DATA_BITS`, 8, payload bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, number of stop bits: 1 or 2.
- Any illegal parameter value fails at elaboration.
- `i_Clock`  in  1  single system clock.
- `i_Reset`  in  1  reset, asynchronous and active-high.
- `i_Tx_DV`  in  1  TX request; accepted only in a cycle with `o_Tx_Ready`=1.
- `i_Tx_Data`  in  DATA_BITS  TX payload, captured on acceptance.
- `o_Tx_Ready`  out  1  TX can accept a request this cycle.
- `o_Tx_Active`  out  1  a TX frame is in progress.
- `o_Tx_Serial`  out  1  serial line; idle level is 1.
- `o_Tx_Done`  out  1  one-cycle pulse when a frame completes.
- `i_Rx_Serial`  in  1  asynchronous serial input.
- `o_Rx_DV`  out  1  one-cycle pulse when a received frame is available.
- `o_Rx_Data`  out  DATA_BITS  received payload; held until the next `o_Rx_DV`.
- `o_Rx_Parity_Err`  out  1  parity mismatch flag; valid with `o_Rx_DV`, held until the next one; always 0 when `PARITY`=0.
- `o_Rx_Frame_Err`  out  1  a stop bit was sampled low; valid with `o_Rx_DV`, held until the next one.

## Operation
- **Reset values:**
  - `o_Tx_Serial`=1, `o_Tx_Ready`=1.
  - `o_Tx_Active`, `o_Tx_Done`, `o_Rx_DV` and both error flags = 0.
  - `o_Rx_Data`=0.
  - RX synchroniser flops = 1.
- **Frame format:** start (0), data LSB first, optional parity bit, then `STOP_BITS`×1.
  - Frame length is N = 1+DATA_BITS+(PARITY≠0)+STOP_BITS bits.
  - Even parity bit = XOR of the data bits; odd parity bit = its inverse.
- **TX FSM:** IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE.
  - Each state lasts `CLKS_PER_BIT` cycles per bit.
  - The bit counter runs 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
  - `o_Tx_Ready`=1 only in IDLE; `o_Tx_Active`=1 outside IDLE.
  - `i_Tx_DV` while not ready is ignored (not queued).
- **RX path:** `i_Rx_Serial` passes through a 2-flop synchroniser.
- **RX FSM:** IDLE → START → DATA → PARITY (optional) → STOP → (WAIT_HIGH on frame error) → IDLE.
  - IDLE: wait for the synchronised line = 0.
  - START: re-sample at count `CLKS_PER_BIT/2`−1 (integer division). If the line is 1, it is a false start: return to IDLE with no DV.
  - Later bits are sampled every `CLKS_PER_BIT` cycles after the start midpoint.
  - Every stop bit is sampled. Any stop sample of 0 sets the frame error.
  - The parity check compares the received parity bit with the parity computed from the received data.
  - `o_Rx_DV` pulses in the cycle after the last stop-bit sample. Data and flags update in that same cycle.
  - Without a frame error, RX returns to IDLE at that point, without waiting for the end of the stop bit.
  - With a frame error, RX waits in WAIT_HIGH until the synchronised line is 1 before entering IDLE. A held-low line (break) therefore produces exactly one DV.
- **Width rules:**
  - Clock counter width is `$clog2(CLKS_PER_BIT)`; it wraps to 0 at `CLKS_PER_BIT`−1.
  - Bit index width is `$clog2(DATA_BITS)`; neither counter ever overflows.
- **Reset mid-operation:** both FSMs go to IDLE asynchronously and `o_Tx_Serial` goes to 1 immediately. No Done or DV is produced for the abandoned frame.

## Timing
- **TX acceptance:** an accepted `i_Tx_DV` in cycle t drives `o_Tx_Serial`=0 and `o_Tx_Active`=1 from cycle t+1.
- **TX completion:** the final stop bit ends at cycle t+N·`CLKS_PER_BIT`. IDLE is entered in the next cycle. In that cycle `o_Tx_Done`=1, `o_Tx_Ready`=1 and `o_Tx_Active`=0.
- **Back-to-back TX:** a DV in the Done cycle is accepted. The new start bit follows with zero idle gap on the line.
- **RX latency:** from the falling edge on `i_Rx_Serial` to `o_Rx_DV` is 2 (synchroniser) + `CLKS_PER_BIT/2` + (N−1)·`CLKS_PER_BIT` + 1 cycles, ±1 cycle for edge phase.
- **Full duplex:** TX and RX are fully independent; simultaneous events on both sides need no arbitration.

## Structure
- **Package `uart_pkg`:**
  - Parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - TX and RX state enums.
  - A parity function (data, mode) → bit.
- **Sub-modules:** `uart_frame` instantiates two sub-modules, `uart_frame_tx` and `uart_frame_rx`. Both share the parameters and `uart_pkg`. There is no logic at top level beyond wiring.

## Test plan
- **TX bit pattern:** `CLKS_PER_BIT`=16, 8 data bits, even parity, 1 stop; send 0xA5. `o_Tx_Serial` must show 0,1,0,1,0,0,1,0,1,0,1, each bit for 16 cycles. `o_Tx_Done` pulses 177 cycles after the accepting edge.
- **Loopback, back-to-back:** TX looped to RX; send 0x00, 0xFF, 0x3C back-to-back. Expect 3 `o_Rx_DV` pulses with matching data, no error flags, and no idle gap between TX frames.
- **Parity error:** odd parity; inject 0x01 with parity bit 1 (the correct bit is 0). Expect DV with `o_Rx_Data`=0x01 and `o_Rx_Parity_Err`=1.
- **Break:** hold the line low for 20 bit times, then high. Expect exactly one DV with data 0x00 and `o_Rx_Frame_Err`=1. A following valid 0x55 frame is received cleanly.
- **False start:** a 4-cycle low glitch with `CLKS_PER_BIT`=16 produces no DV, and RX remains in IDLE.
- **Reset mid-TX:** assert `i_Reset` during data bit 3. `o_Tx_Serial`=1 immediately, no Done pulse, and `o_Tx_Ready`=1. After release, a new DV with 0x5A transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state
// encodings and the parity helper used by both directions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Payload is zero-extended to the widest legal frame; padding does not alter the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// UART receiver: synchronised input, mid-bit sampling, false-start rejection,
// parity and framing error flags, and break handling via WAIT_HIGH.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Parity_Err,
  output logic                 o_Rx_Frame_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 bit_end;
  logic                 ferr_now;

  assign rx_s    = sync_q[1];
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_q     <= 2'b11;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ferr_q     <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_Rx_Serial};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ferr_q     <= ferr_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    dv_d       = 1'b0;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ferr_now   = ferr_q | ~rx_s;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      // Mid-start re-check: a line already back high is a glitch, not a frame.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          bit_d  = '0;
          ferr_d = 1'b0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (bit_end) begin
          par_d   = rx_s;
          state_d = RX_STOP;
          bit_d   = '0;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          ferr_d = ferr_now;
          if (bit_q == STOP_LAST) begin
            dv_d       = 1'b1;
            data_d     = shift_q;
            perr_out_d = (PARITY != PAR_NONE) && (par_q != parity_bit(9'(shift_q), PARITY));
            ferr_out_d = ferr_now;
            state_d    = ferr_now ? RX_WAIT_HIGH : RX_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_Rx_DV         = dv_q;
  assign o_Rx_Data       = data_q;
  assign o_Rx_Parity_Err = perr_out_q;
  assign o_Rx_Frame_Err  = ferr_out_q;

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter: start, LSB-first data, optional parity, 1..2 stop bits,
// with a ready/valid request port that accepts a new frame in the Done cycle.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (state_q != TX_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (i_Tx_DV) begin
          state_d = TX_START;
          data_d  = i_Tx_Data;
          cnt_d   = '0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          bit_d   = '0;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level decoded from state so an async reset forces idle-high at once.
  always_comb begin
    case (state_q)
      TX_START:  o_Tx_Serial = 1'b0;
      TX_DATA:   o_Tx_Serial = data_q[bit_q];
      TX_PARITY: o_Tx_Serial = parity_bit(9'(data_q), PARITY);
      default:   o_Tx_Serial = 1'b1;
    endcase
  end

  assign o_Tx_Ready  = (state_q == TX_IDLE);
  assign o_Tx_Active = (state_q != TX_IDLE);
  assign o_Tx_Done   = done_q;

endmodule

// File: rtl/uart_frame.sv
// Full-duplex parametrised UART top: independent TX and RX engines sharing
// the frame parameters; wiring only.
module uart_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Parity_Err,
  output logic                 o_Rx_Frame_Err
);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_frame: illegal parameter combination");
  end

  uart_frame_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS), .PARITY(PARITY), .STOP_BITS(STOP_BITS)
  ) u_tx (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Tx_DV    (i_Tx_DV),
    .i_Tx_Data  (i_Tx_Data),
    .o_Tx_Ready (o_Tx_Ready),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done  (o_Tx_Done)
  );

  uart_frame_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS), .PARITY(PARITY), .STOP_BITS(STOP_BITS)
  ) u_rx (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Rx_Serial    (i_Rx_Serial),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Data      (o_Rx_Data),
    .o_Rx_Parity_Err(o_Rx_Parity_Err),
    .o_Rx_Frame_Err (o_Rx_Frame_Err)
  );

endmodule
